// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus stability-qualified debouncer.
// Produces a clean level, its complement and edge pulses.
module debounce_sync #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic clear_n,
    input  logic d_in,
    output logic q,
    output logic qbar,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             s1;
    logic             s2;
    logic             q_n;
    logic             rise_n;
    logic             fall_n;
    logic             busy_n;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= LOW;
            cnt   <= '0;
            q     <= 1'b0;
            qbar  <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
            qbar  <= ~q_n;
            rise  <= rise_n;
            fall  <= fall_n;
            busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        unique case (state)
            LOW: begin
                if (s2) begin
                    state_n = WAIT_HIGH;
                    cnt_n   = ONE;
                end else begin
                    cnt_n = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == LIMIT) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    q_n     = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_n = WAIT_LOW;
                    cnt_n   = ONE;
                end else begin
                    cnt_n = '0;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == LIMIT) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    q_n     = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
            end
        endcase
        // busy mirrors the registered state being a qualifying one
        busy_n = (state_n == WAIT_HIGH) || (state_n == WAIT_LOW);
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Randomized scoreboard bench for debounce_sync.
// Two instances (STABLE_CYCLES 8 and 1) share one stimulus stream.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    logic d_in = 1'b0;

    logic q0, qbar0, rise0, fall0, busy0;
    logic q1, qbar1, rise1, fall1, busy1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    // reference: s2 as seen by the FSM is d_in delayed two edges;
    // q flips once the run of samples differing from q hits SC+1
    int   scv[2] = '{8, 1};
    logic m_s1[2] = '{1'b0, 1'b0};
    logic m_s2[2] = '{1'b0, 1'b0};
    logic mq[2] = '{1'b0, 1'b0};
    int   run[2] = '{0, 0};

    always #5 clk = ~clk;

    debounce_sync #(.STABLE_CYCLES(8), .CNT_W(4)) dut0 (
        .clk(clk), .clear_n(clear_n), .d_in(d_in),
        .q(q0), .qbar(qbar0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    debounce_sync #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .clear_n(clear_n), .d_in(d_in),
        .q(q1), .qbar(qbar1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    function automatic exp_t step(int i, logic d);
        exp_t e;
        logic v;
        v = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = d;
        if (v != mq[i]) run[i] = run[i] + 1;
        else run[i] = 0;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (run[i] == scv[i] + 1) begin
            mq[i] = v;
            run[i] = 0;
            e.rise = v;
            e.fall = ~v;
        end
        e.q = mq[i];
        e.busy = (run[i] != 0);
        return e;
    endfunction

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 1'b0;
                m_s2[i] = 1'b0;
                mq[i] = 1'b0;
                run[i] = 0;
            end
            sb0.delete();
            sb1.delete();
        end else begin
            sb0.push_back(step(0, d_in));
            sb1.push_back(step(1, d_in));
        end
    end

    task automatic check(string name, logic [4:0] got, logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got q/qbar/rise/fall/busy=%b want=%b",
                     name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!clear_n) begin
            check("reset0", {q0, qbar0, rise0, fall0, busy0}, 5'b01000);
            check("reset1", {q1, qbar1, rise1, fall1, busy1}, 5'b01000);
        end else begin
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                check("sc8", {q0, qbar0, rise0, fall0, busy0},
                      {e.q, ~e.q, e.rise, e.fall, e.busy});
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                check("sc1", {q1, qbar1, rise1, fall1, busy1},
                      {e.q, ~e.q, e.rise, e.fall, e.busy});
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic hold(logic lvl, int n);
        d_in = lvl;
        cyc(n);
    endtask

    task automatic mid_reset(int n);
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        cyc(n);
        clear_n = 1'b1;
    endtask

    int rise_edge;

    initial begin
        clear_n = 1'b0;
        d_in = 1'b1;
        cyc(3);
        clear_n = 1'b1;
        // count edges from release to the rise pulse
        rise_edge = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rise0 && rise_edge == 0) rise_edge = k;
        end
        checks++;
        if (rise_edge != 11) begin
            errors++;
            $display("FAIL rise_latency got edge %0d want 11", rise_edge);
        end
        cyc(1);
        hold(1'b0, 15);
        hold(1'b1, 5);
        hold(1'b0, 15);
        for (int k = 0; k < 10; k++) hold(k[0] ? 1'b0 : 1'b1, 2);
        hold(1'b1, 15);
        hold(1'b0, 15);
        d_in = 1'b1;
        cyc(6);
        d_in = 1'b0;
        mid_reset(2);
        hold(1'b0, 15);
        hold(1'b1, 1);
        hold(1'b0, 10);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                mid_reset($urandom_range(1, 3));
            end
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
        end
        hold(1'b0, 15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
